// File: rtl/reg_file.sv
// Architectural integer register file: 32 x 32-bit, x0 hardwired to zero,
// combinational reads, synchronous writes, optional bypass via REG_FILE_BYPASS_EN.
module reg_file #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_reg,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_reg_1,
   input  logic [ADDR_WIDTH-1:0] rd_reg_2,
   output logic [DATA_WIDTH-1:0] rd_data_1,
   output logic [DATA_WIDTH-1:0] rd_data_2
);

   // Storage starts at index 1; x0 has no flops.
   logic [DATA_WIDTH-1:0] regs [NUM_REGS-1:1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (wr_en && (wr_reg == ADDR_WIDTH'(i))) begin
               regs[i] <= wr_data;
            end
         end
      end
   end

   always_comb begin
      rd_data_1 = '0;
      rd_data_2 = '0;
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
         if (rd_reg_1 == ADDR_WIDTH'(i)) rd_data_1 = regs[i];
         if (rd_reg_2 == ADDR_WIDTH'(i)) rd_data_2 = regs[i];
      end
`ifdef REG_FILE_BYPASS_EN
      // Gated by rst_n so a held reset still reads zero on every index.
      if (rst_n && wr_en && (wr_reg != '0)) begin
         if (rd_reg_1 == wr_reg) rd_data_1 = wr_data;
         if (rd_reg_2 == wr_reg) rd_data_2 = wr_data;
      end
`endif
   end

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file; follows REG_FILE_BYPASS_EN when defined.
module tb_reg_file;

   logic        clk;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_reg;
   logic [31:0] wr_data;
   logic [4:0]  rd_reg_1;
   logic [4:0]  rd_reg_2;
   logic [31:0] rd_data_1;
   logic [31:0] rd_data_2;

   reg_file #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model [32];
   logic        sample;
   int          n_tests;
   int          n_fail;
   bit          bypass;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL timeout: run did not complete");
      $fatal(1, "timeout");
   end

   // Reference read: architectural value, plus same-cycle forwarding if compiled in.
   function automatic logic [31:0] ref_read(input logic [4:0] r);
      logic [31:0] v;
      v = (r == 5'd0) ? 32'd0 : model[r];
      if (bypass && rst_n && wr_en && wr_reg != 5'd0 && wr_reg == r && r != 5'd0) v = wr_data;
      return v;
   endfunction

   // Monitor: DUT outputs are observed at the falling edge when the stimulus flagged a read.
   always @(negedge clk) begin
      if (sample) begin
         exp_t e;
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: got %h/%h, required an expected entry", rd_data_1, rd_data_2);
         end else begin
            e = sb.pop_front();
            if (rd_data_1 !== e.a || rd_data_2 !== e.b) begin
               n_fail++;
               $display("FAIL %s: rd1=%h rd2=%h, required rd1=%h rd2=%h", e.tag, rd_data_1, rd_data_2, e.a, e.b);
            end
         end
      end
   end

   // One cycle of stimulus starting 1 time unit after a rising edge.
   task automatic cyc(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit chk, input string tag);
      exp_t e;
      wr_en = we; wr_reg = wr; wr_data = wd; rd_reg_1 = r1; rd_reg_2 = r2;
      if (chk) begin
         e.a = ref_read(r1); e.b = ref_read(r2); e.tag = tag;
         sb.push_back(e);
      end
      sample = chk;
      @(posedge clk);
      if (rst_n && we && wr != 5'd0) model[wr] = wd;
      #1;
      sample = 1'b0;
   endtask

   initial begin
      logic [31:0] diff;
      exp_t        e;
      bypass = 1'b0;
`ifdef REG_FILE_BYPASS_EN
      bypass = 1'b1;
`endif
      n_tests = 0; n_fail = 0; sample = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      rst_n = 1'b0; wr_en = 1'b0; wr_reg = '0; wr_data = '0; rd_reg_1 = '0; rd_reg_2 = '0;
      @(posedge clk); #1;
      cyc(1'b1, 5'd3, 32'hCAFE0003, 5'd3, 5'd31, 1'b1, "reset_hold_blocks_write");
      rst_n = 1'b1;
      cyc(1'b0, 5'd0, 32'd0, 5'd3, 5'd17, 1'b1, "reset_state");

      // Mid-cycle asynchronous clear, observed before the next rising edge.
      cyc(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 1'b1, "x5_write_pre_reset");
      cyc(1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 1'b1, "x5_readback");
      wr_en = 1'b1; wr_reg = 5'd5; wr_data = 32'h11111111; rd_reg_1 = 5'd5; rd_reg_2 = 5'd5;
      #2 rst_n = 1'b0;
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      e.a = 32'd0; e.b = 32'd0; e.tag = "async_reset_clear";
      sb.push_back(e); sample = 1'b1;
      @(posedge clk); #1; sample = 1'b0;
      rst_n = 1'b1;

      cyc(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, "x0_write_same_cycle");
      cyc(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b1, "x0_hardwire");

      for (int i = 1; i < 32; i++)
         cyc(1'b1, 5'(i), 32'(i) * 32'h01010101, 5'($urandom_range(0, 31)), 5'(i), 1'b1, "fill_write");
      for (int i = 0; i < 32; i++)
         cyc(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 1'b1, "pair_readback");

      cyc(1'b1, 5'd10, 32'h12345678, 5'd10, 5'd0, 1'b1, "x10_write");
      cyc(1'b0, 5'd10, 32'd0, 5'd10, 5'd10, 1'b1, "wr_en_gating");
      cyc(1'b0, 5'd0, 32'd0, 5'd10, 5'd9, 1'b1, "wr_en_gating_after");

      cyc(1'b1, 5'd7, 32'hAAAA0000, 5'd1, 5'd2, 1'b0, "");
      cyc(1'b1, 5'd7, 32'h5555FFFF, 5'd7, 5'd0, 1'b1, "collision_before_edge");
      cyc(1'b0, 5'd0, 32'd0, 5'd7, 5'd7, 1'b1, "collision_after_edge");

      // Operand feed: SUB of two equal registers must give result 0, zero flag 1.
      cyc(1'b1, 5'd1, 32'd7, 5'd0, 5'd0, 1'b0, "");
      cyc(1'b1, 5'd2, 32'd7, 5'd0, 5'd0, 1'b0, "");
      wr_en = 1'b0; rd_reg_1 = 5'd1; rd_reg_2 = 5'd2;
      #1;
      diff = rd_data_1 - rd_data_2;
      n_tests++;
      if (diff !== 32'd0 || rd_data_1 !== 32'd7) begin
         n_fail++;
         $display("FAIL alu_sub_zero: in_a=%h in_b=%h result=%h, required in_a=7 result=0 zero=1",
                  rd_data_1, rd_data_2, diff);
      end
      @(posedge clk); #1;

      for (int k = 0; k < 400; k++)
         cyc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, "random");

      @(posedge clk); #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
